parc_core_reorder_buffer: RTL and testbench

In-order retirement buffer for the 5-stage PARC core. Issue allocates one slot per accepted instruction; the slot number is handed to the scoreboard so it can tag the destination register. Functional units mark slots complete at writeback. The head slot retires in program order and drives the register-file write and the scoreboard's pending-clear (commit slot and wen).

---
 rtl/parc_core_reorder_buffer.sv | 135 +++++++++++++
 tb/tb_parc_core_reorder_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/parc_core_reorder_buffer.sv
// ----------------------------------------------------------------------------
// parc_core_reorder_buffer
//
// In-order retirement buffer for the 5-stage PARC core. Issue allocates one
// slot per accepted instruction at the tail. Writeback marks slots complete.
// The head slot retires in program order and produces the register-file write
// and the scoreboard pending-clear.
//
// Optional build macro:
//   ROB_FILL_COMMIT_BYPASS_EN  - a fill to the valid head slot retires it in
//                                the same cycle (0-cycle fill-to-commit).
//                                Undefined: the fill is registered first and
//                                the head commits one cycle later.
//
// Ports:
//   clk                  core clock
//   reset                synchronous, active-high reset
//   rob_alloc_req_val    issue requests a slot this cycle
//   rob_alloc_req_rdy    a slot is free
//   rob_alloc_req_wen    allocated instruction writes a register
//   rob_alloc_req_preg   destination register of the allocated instruction
//   rob_alloc_resp_slot  slot granted (tail pointer)
//   rob_fill_val         writeback marks a slot complete
//   rob_fill_slot        slot being completed
//   rob_commit_val       head retires this cycle
//   rob_commit_wen       retiring instruction writes the register file
//   rob_commit_slot      slot retiring (head pointer)
//   rob_commit_rf_waddr  register-file write address of the retiring entry
//   rob_empty            no valid entries
//   rob_full             all entries valid
// ----------------------------------------------------------------------------
module parc_core_reorder_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rob_alloc_req_val,
    output logic       rob_alloc_req_rdy,
    input  logic       rob_alloc_req_wen,
    input  logic [4:0] rob_alloc_req_preg,
    output logic [3:0] rob_alloc_resp_slot,
    input  logic       rob_fill_val,
    input  logic [3:0] rob_fill_slot,
    output logic       rob_commit_val,
    output logic       rob_commit_wen,
    output logic [3:0] rob_commit_slot,
    output logic [4:0] rob_commit_rf_waddr,
    output logic       rob_empty,
    output logic       rob_full
);

    // ENTRIES is a power of two, so masking implements the wrap to zero.
    localparam logic [3:0] PTR_MASK  = 4'(ENTRIES - 1);
    localparam logic [4:0] COUNT_MAX = 5'(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] pending_q;
    logic [ENTRIES-1:0] wen_q;
    logic [4:0]         preg_q [ENTRIES];

    logic [3:0] head_q;
    logic [3:0] tail_q;
    logic [4:0] count_q;

    logic [3:0] head_next;
    logic [3:0] tail_next;
    logic       alloc_fire;
    logic       fill_hit;
    logic       head_fill;
    logic       head_ready;
    logic       commit_fire;

    assign head_next = (head_q + 4'd1) & PTR_MASK;
    assign tail_next = (tail_q + 4'd1) & PTR_MASK;

    assign rob_full            = (count_q == COUNT_MAX);
    assign rob_empty           = (count_q == 5'd0);
    assign rob_alloc_req_rdy   = !rob_full;
    assign rob_alloc_resp_slot = tail_q;
    assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;

    // A fill only lands on a slot that is already valid. The slot being
    // allocated this cycle is still invalid, so a fill to it drops out here.
    assign fill_hit  = rob_fill_val && ({1'b0, rob_fill_slot} < COUNT_MAX)
                       && valid_q[rob_fill_slot];
    assign head_fill = rob_fill_val && (rob_fill_slot == head_q);

`ifdef ROB_FILL_COMMIT_BYPASS_EN
    assign head_ready = !pending_q[head_q] || head_fill;
`else
    assign head_ready = !pending_q[head_q];
`endif

    // Commit is suppressed while reset is asserted so a discarded entry never
    // reaches the register file in the reset cycle.
    assign commit_fire         = !reset && valid_q[head_q] && head_ready;
    assign rob_commit_val      = commit_fire;
    assign rob_commit_slot     = head_q;
    assign rob_commit_wen      = commit_fire ? wen_q[head_q] : 1'b0;
    assign rob_commit_rf_waddr = commit_fire ? preg_q[head_q] : 5'd0;

    // Slot state and pointers. Alloc writes the tail, commit clears the head;
    // the two never collide because alloc needs a free slot and commit needs
    // a valid one. The count moves only when exactly one of them happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            pending_q <= '0;
            head_q    <= 4'd0;
            tail_q    <= 4'd0;
            count_q   <= 5'd0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q]   <= 1'b1;
                pending_q[tail_q] <= 1'b1;
                wen_q[tail_q]     <= rob_alloc_req_wen;
                preg_q[tail_q]    <= rob_alloc_req_preg;
                tail_q            <= tail_next;
            end
            if (fill_hit) begin
                pending_q[rob_fill_slot] <= 1'b0;
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_next;
            end
            if (alloc_fire && !commit_fire) begin
                count_q <= count_q + 5'd1;
            end else if (!alloc_fire && commit_fire) begin
                count_q <= count_q - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_parc_core_reorder_buffer
//
// Directed, table-driven bench for parc_core_reorder_buffer (ENTRIES=16).
// Each vector holds the inputs for one cycle and the outputs expected during
// that cycle, before the next rising edge. Expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_parc_core_reorder_buffer;

`ifdef ROB_FILL_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       a_val;
        logic       a_wen;
        logic [4:0] a_preg;
        logic       f_val;
        logic [3:0] f_slot;
        logic       e_rdy;
        logic [3:0] e_resp;
        logic       e_cv;
        logic       e_cw;
        logic [3:0] e_cs;
        logic [4:0] e_wa;
        logic       e_empty;
        logic       e_full;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       rob_alloc_req_val;
    logic       rob_alloc_req_rdy;
    logic       rob_alloc_req_wen;
    logic [4:0] rob_alloc_req_preg;
    logic [3:0] rob_alloc_resp_slot;
    logic       rob_fill_val;
    logic [3:0] rob_fill_slot;
    logic       rob_commit_val;
    logic       rob_commit_wen;
    logic [3:0] rob_commit_slot;
    logic [4:0] rob_commit_rf_waddr;
    logic       rob_empty;
    logic       rob_full;

    int vectors;
    int miscompares;

    vec_t tbl[$];

    parc_core_reorder_buffer #(.ENTRIES(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .rob_alloc_req_val   (rob_alloc_req_val),
        .rob_alloc_req_rdy   (rob_alloc_req_rdy),
        .rob_alloc_req_wen   (rob_alloc_req_wen),
        .rob_alloc_req_preg  (rob_alloc_req_preg),
        .rob_alloc_resp_slot (rob_alloc_resp_slot),
        .rob_fill_val        (rob_fill_val),
        .rob_fill_slot       (rob_fill_slot),
        .rob_commit_val      (rob_commit_val),
        .rob_commit_wen      (rob_commit_wen),
        .rob_commit_slot     (rob_commit_slot),
        .rob_commit_rf_waddr (rob_commit_rf_waddr),
        .rob_empty           (rob_empty),
        .rob_full            (rob_full)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic av, input logic aw, input logic [4:0] ap,
                                input logic fv, input logic [3:0] fs,
                                input logic rdy, input logic [3:0] resp,
                                input logic cv, input logic cw, input logic [3:0] cs,
                                input logic [4:0] wa, input logic emp, input logic ful);
        vec_t v;
        v.a_val = av;  v.a_wen = aw;   v.a_preg = ap;
        v.f_val = fv;  v.f_slot = fs;
        v.e_rdy = rdy; v.e_resp = resp;
        v.e_cv = cv;   v.e_cw = cw;    v.e_cs = cs; v.e_wa = wa;
        v.e_empty = emp; v.e_full = ful;
        return v;
    endfunction

    // Compare every output against the vector; one FAIL line per bad field.
    task automatic checkOutput(input string name, input vec_t v);
        vectors++;
        if (rob_alloc_req_rdy !== v.e_rdy) begin
            miscompares++;
            $display("[TB] FAIL %s rdy: got %b want %b", name, rob_alloc_req_rdy, v.e_rdy);
        end
        if (rob_alloc_resp_slot !== v.e_resp) begin
            miscompares++;
            $display("[TB] FAIL %s resp_slot: got %0d want %0d", name, rob_alloc_resp_slot, v.e_resp);
        end
        if (rob_commit_val !== v.e_cv) begin
            miscompares++;
            $display("[TB] FAIL %s commit_val: got %b want %b", name, rob_commit_val, v.e_cv);
        end
        if (rob_commit_wen !== v.e_cw) begin
            miscompares++;
            $display("[TB] FAIL %s commit_wen: got %b want %b", name, rob_commit_wen, v.e_cw);
        end
        if (rob_commit_slot !== v.e_cs) begin
            miscompares++;
            $display("[TB] FAIL %s commit_slot: got %0d want %0d", name, rob_commit_slot, v.e_cs);
        end
        if (rob_commit_rf_waddr !== v.e_wa) begin
            miscompares++;
            $display("[TB] FAIL %s rf_waddr: got %0d want %0d", name, rob_commit_rf_waddr, v.e_wa);
        end
        if (rob_empty !== v.e_empty) begin
            miscompares++;
            $display("[TB] FAIL %s empty: got %b want %b", name, rob_empty, v.e_empty);
        end
        if (rob_full !== v.e_full) begin
            miscompares++;
            $display("[TB] FAIL %s full: got %b want %b", name, rob_full, v.e_full);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and check just after.
    task automatic applyStimulus(input string name, input vec_t v);
        @(negedge clk);
        rob_alloc_req_val  = v.a_val;
        rob_alloc_req_wen  = v.a_wen;
        rob_alloc_req_preg = v.a_preg;
        rob_fill_val       = v.f_val;
        rob_fill_slot      = v.f_slot;
        #1;
        checkOutput(name, v);
    endtask

    // Hold reset for one cycle with idle inputs; no commit may show meanwhile.
    task automatic resetCycle(input string name);
        @(negedge clk);
        reset              = 1'b1;
        rob_alloc_req_val  = 1'b0;
        rob_fill_val       = 1'b0;
        #1;
        vectors++;
        if (rob_commit_val !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s commit_val in reset: got %b want 0", name, rob_commit_val);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        reset              = 1'b1;
        rob_alloc_req_val  = 1'b0;
        rob_alloc_req_wen  = 1'b0;
        rob_alloc_req_preg = 5'd0;
        rob_fill_val       = 1'b0;
        rob_fill_slot      = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Three allocations, out-of-order fills, then in-order drain.
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd0, 0,0,4'd0,5'd0, 1,0));
        tbl.push_back(mk(1,1,5'd5, 0,4'd0, 1,4'd0, 0,0,4'd0,5'd0, 1,0));
        tbl.push_back(mk(1,1,5'd6, 0,4'd0, 1,4'd1, 0,0,4'd0,5'd0, 0,0));
        tbl.push_back(mk(1,1,5'd7, 0,4'd0, 1,4'd2, 0,0,4'd0,5'd0, 0,0));
        tbl.push_back(mk(0,0,5'd0, 1,4'd2, 1,4'd3, 0,0,4'd0,5'd0, 0,0));
        tbl.push_back(mk(0,0,5'd0, 1,4'd1, 1,4'd3, 0,0,4'd0,5'd0, 0,0));
`ifdef ROB_FILL_COMMIT_BYPASS_EN
        tbl.push_back(mk(0,0,5'd0, 1,4'd0, 1,4'd3, 1,1,4'd0,5'd5, 0,0));
`else
        tbl.push_back(mk(0,0,5'd0, 1,4'd0, 1,4'd3, 0,0,4'd0,5'd0, 0,0));
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd3, 1,1,4'd0,5'd5, 0,0));
`endif
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd3, 1,1,4'd1,5'd6, 0,0));
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd3, 1,1,4'd2,5'd7, 0,0));
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd3, 0,0,4'd3,5'd0, 1,0));
        // Two entries at slots 3,4; a fill to invalid slot 9 does nothing.
        tbl.push_back(mk(1,0,5'd1, 0,4'd0, 1,4'd3, 0,0,4'd3,5'd0, 1,0));
        tbl.push_back(mk(1,1,5'd2, 0,4'd0, 1,4'd4, 0,0,4'd3,5'd0, 0,0));
        tbl.push_back(mk(0,0,5'd0, 1,4'd9, 1,4'd5, 0,0,4'd3,5'd0, 0,0));
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd5, 0,0,4'd3,5'd0, 0,0));
        // Head fill of a wen=0 entry: commit now (bypass) or next cycle.
        tbl.push_back(mk(0,0,5'd0, 1,4'd3, 1,4'd5, BYP,0,4'd3,BYP ? 5'd1 : 5'd0, 0,0));
        tbl.push_back(mk(0,0,5'd0, 0,4'd0, 1,4'd5, !BYP,0,BYP ? 4'd4 : 4'd3,
                         BYP ? 5'd0 : 5'd1, 0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus($sformatf("tbl%0d", i), tbl[i]);
        end

        resetCycle("rst_a");
        applyStimulus("post_rst_a", mk(0,0,5'd0, 0,4'd0, 1,4'd0, 0,0,4'd0,5'd0, 1,0));

        // Fill the buffer with no completions; slot i gets preg i.
        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("fill_up%0d", i),
                          mk(1,1,5'(i), 0,4'd0, 1,4'(i), 0,0,4'd0,5'd0, i == 0, 0));
        end
        applyStimulus("full_hold", mk(1,1,5'd20, 0,4'd0, 0,4'd0, 0,0,4'd0,5'd0, 0,1));
        applyStimulus("full_fill0", mk(1,1,5'd20, 1,4'd0, 0,4'd0, BYP,BYP,4'd0,5'd0, 0,1));
`ifndef ROB_FILL_COMMIT_BYPASS_EN
        applyStimulus("full_commit0", mk(1,1,5'd20, 0,4'd0, 0,4'd0, 1,1,4'd0,5'd0, 0,1));
`endif
        applyStimulus("wrap_alloc", mk(1,1,5'd20, 0,4'd0, 1,4'd0, 0,0,4'd1,5'd0, 0,0));
        // Younger slot 5 completes first; head slot 1 must still wait.
        applyStimulus("ooo_fill5", mk(0,0,5'd0, 1,4'd5, 0,4'd1, 0,0,4'd1,5'd0, 0,1));
        applyStimulus("ooo_wait", mk(0,0,5'd0, 0,4'd0, 0,4'd1, 0,0,4'd1,5'd0, 0,1));
        applyStimulus("head_fill1", mk(0,0,5'd0, 1,4'd1, 0,4'd1, BYP,BYP,4'd1,
                                       BYP ? 5'd1 : 5'd0, 0,1));

        // Reset lands in the cycle where slot 1 would otherwise retire.
        resetCycle("rst_b");
        applyStimulus("post_rst_b", mk(0,0,5'd0, 0,4'd0, 1,4'd0, 0,0,4'd0,5'd0, 1,0));

        // Five valid entries, head completed, then reset discards all.
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("five%0d", i),
                          mk(1,1,5'(i + 8), 0,4'd0, 1,4'(i), 0,0,4'd0,5'd0, i == 0, 0));
        end
        applyStimulus("five_fill0", mk(0,0,5'd0, 1,4'd0, 1,4'd5, BYP,BYP,4'd0,
                                       BYP ? 5'd8 : 5'd0, 0,0));
        resetCycle("rst_c");
        applyStimulus("post_rst_c", mk(0,0,5'd0, 0,4'd0, 1,4'd0, 0,0,4'd0,5'd0, 1,0));
        applyStimulus("post_rst_c2", mk(0,0,5'd0, 0,4'd0, 1,4'd0, 0,0,4'd0,5'd0, 1,0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
